// File: rtl/ddram_arb_pkg.sv
// Shared types and default widths for the DDRAM two-port arbiter and its picker.
package ddram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CMD     = 2'd1,
      RD_DATA = 2'd2,
      WR_DATA = 2'd3
   } arb_state_t;

   localparam int AW_DEF  = 29;
   localparam int DW_DEF  = 64;
   localparam int BCW_DEF = 8;

endpackage

// File: rtl/ddram_arb_pick.sv
// Two-way request picker: a lone requester wins. On a tie, round-robin mode
// grants the port not served last, and fixed-priority mode grants port 0.
module ddram_arb_pick
   import ddram_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  logic       rr,
   output logic       gnt_next
);

   always_comb begin
      gnt_next = 1'b0;
      case (req)
         2'b01:   gnt_next = 1'b0;
         2'b10:   gnt_next = 1'b1;
         2'b11:   gnt_next = rr ? ~last : 1'b0;
         default: gnt_next = 1'b0;
      endcase
   end

endmodule

// File: rtl/ddram_arb.sv
// Two-port arbiter for the DDRAM Avalon-MM burst master. It runs one read or
// write burst at a time and holds the grant until that burst completes.
module ddram_arb
   import ddram_arb_pkg::*;
#(
   parameter int AW  = AW_DEF,
   parameter int DW  = DW_DEF,
   parameter int BCW = BCW_DEF,
   parameter bit RR  = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,

   input  logic [AW-1:0]     p0_addr,
   input  logic [BCW-1:0]    p0_burstcnt,
   input  logic              p0_rd,
   input  logic              p0_we,
   input  logic [DW-1:0]     p0_din,
   input  logic [DW/8-1:0]   p0_be,
   output logic              p0_busy,
   output logic [DW-1:0]     p0_dout,
   output logic              p0_dout_ready,

   input  logic [AW-1:0]     p1_addr,
   input  logic [BCW-1:0]    p1_burstcnt,
   input  logic              p1_rd,
   input  logic              p1_we,
   input  logic [DW-1:0]     p1_din,
   input  logic [DW/8-1:0]   p1_be,
   output logic              p1_busy,
   output logic [DW-1:0]     p1_dout,
   output logic              p1_dout_ready,

   output logic              DDRAM_CLK,
   input  logic              DDRAM_BUSY,
   output logic [BCW-1:0]    DDRAM_BURSTCNT,
   output logic [AW-1:0]     DDRAM_ADDR,
   input  logic [DW-1:0]     DDRAM_DOUT,
   input  logic              DDRAM_DOUT_READY,
   output logic              DDRAM_RD,
   output logic [DW-1:0]     DDRAM_DIN,
   output logic [DW/8-1:0]   DDRAM_BE,
   output logic              DDRAM_WE
);

   arb_state_t     state_reg, state_next;
   logic           gnt_reg,   gnt_next;
   logic           last_reg,  last_next;
   logic [BCW-1:0] cnt_reg,   cnt_next;

   logic [1:0]     req;
   logic           pick_gnt;

   logic           own_rd;
   logic           own_we_raw;
   logic           own_we;
   logic [AW-1:0]  own_addr;
   logic [BCW-1:0] own_bc;
   logic [BCW-1:0] own_bc_eff;
   logic [DW-1:0]  own_din;
   logic [DW/8-1:0] own_be;

   logic           owner_busy;
   logic           owner_rdy;
   logic           ddr_rd;
   logic           ddr_we;
   logic [1:0]     busy_vec;
   logic [1:0]     rdy_vec;

   assign req = {p1_rd | p1_we, p0_rd | p0_we};

   ddram_arb_pick u_pick (
      .req      (req),
      .last     (last_reg),
      .rr       (RR),
      .gnt_next (pick_gnt)
   );

   // Owner mux: everything the DDRAM master sees comes from the granted port.
   always_comb begin
      own_rd     = gnt_reg ? p1_rd       : p0_rd;
      own_we_raw = gnt_reg ? p1_we       : p0_we;
      own_addr   = gnt_reg ? p1_addr     : p0_addr;
      own_bc     = gnt_reg ? p1_burstcnt : p0_burstcnt;
      own_din    = gnt_reg ? p1_din      : p0_din;
      own_be     = gnt_reg ? p1_be       : p0_be;
   end

   // A simultaneous rd and we is treated as a read.
   assign own_we     = own_we_raw & ~own_rd;
   assign own_bc_eff = (own_bc == '0) ? BCW'(1) : own_bc;

   always_comb begin
      state_next = state_reg;
      gnt_next   = gnt_reg;
      last_next  = last_reg;
      cnt_next   = cnt_reg;
      ddr_rd     = 1'b0;
      ddr_we     = 1'b0;
      owner_busy = 1'b1;
      owner_rdy  = 1'b0;

      case (state_reg)
         IDLE: begin
            if (|req) begin
               gnt_next   = pick_gnt;
               state_next = CMD;
            end
         end

         CMD: begin
            ddr_rd     = own_rd;
            ddr_we     = own_we;
            owner_busy = DDRAM_BUSY;
            if (own_rd && !DDRAM_BUSY) begin
               cnt_next   = own_bc_eff;
               state_next = RD_DATA;
            end else if (own_we && !DDRAM_BUSY) begin
               if (own_bc_eff == BCW'(1)) begin
                  last_next  = gnt_reg;
                  state_next = IDLE;
               end else begin
                  cnt_next   = own_bc_eff - BCW'(1);
                  state_next = WR_DATA;
               end
            end else if (!own_rd && !own_we_raw) begin
               // Requester withdrew before acceptance: nothing was issued.
               state_next = IDLE;
            end
         end

         RD_DATA: begin
            if (DDRAM_DOUT_READY) begin
               owner_rdy = 1'b1;
               cnt_next  = cnt_reg - BCW'(1);
               if (cnt_reg == BCW'(1)) begin
                  last_next  = gnt_reg;
                  state_next = IDLE;
               end
            end
         end

         WR_DATA: begin
            ddr_we     = own_we_raw;
            owner_busy = DDRAM_BUSY;
            if (own_we_raw && !DDRAM_BUSY) begin
               cnt_next = cnt_reg - BCW'(1);
               if (cnt_reg == BCW'(1)) begin
                  last_next  = gnt_reg;
                  state_next = IDLE;
               end
            end
         end

         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         gnt_reg   <= 1'b0;
         last_reg  <= 1'b1;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         gnt_reg   <= gnt_next;
         last_reg  <= last_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Only the owner sees DDRAM waitrequest and read strobes; the other port is held off.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         assign busy_vec[gi] = (gnt_reg == 1'(gi)) ? owner_busy : 1'b1;
         assign rdy_vec[gi]  = (gnt_reg == 1'(gi)) ? owner_rdy  : 1'b0;
      end
   endgenerate

   assign p0_busy       = busy_vec[0];
   assign p1_busy       = busy_vec[1];
   assign p0_dout_ready = rdy_vec[0];
   assign p1_dout_ready = rdy_vec[1];
   assign p0_dout       = DDRAM_DOUT;
   assign p1_dout       = DDRAM_DOUT;

   assign DDRAM_CLK      = clk;
   assign DDRAM_RD       = ddr_rd;
   assign DDRAM_WE       = ddr_we;
   assign DDRAM_ADDR     = own_addr;
   assign DDRAM_BURSTCNT = own_bc_eff;
   assign DDRAM_DIN      = own_din;
   assign DDRAM_BE       = own_be;

endmodule

// File: tb/tb_ddram_arb.sv
// Cycle-scripted bench for ddram_arb: a round-robin instance is driven from a vector
// table, and a fixed-priority instance sharing the same inputs gets its own check.
module tb_ddram_arb;

   localparam int AW  = 29;
   localparam int DW  = 64;
   localparam int BCW = 8;

   localparam logic [AW-1:0] A0 = 29'h100;
   localparam logic [AW-1:0] A1 = 29'h200;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CMD  = 2'd1;
   localparam logic [1:0] S_RD   = 2'd2;
   localparam logic [1:0] S_WR   = 2'd3;

   logic             clk;
   logic             reset_n;
   logic [AW-1:0]    p0_addr, p1_addr;
   logic [BCW-1:0]   p0_burstcnt, p1_burstcnt;
   logic             p0_rd, p0_we, p1_rd, p1_we;
   logic [DW-1:0]    p0_din, p1_din;
   logic [DW/8-1:0]  p0_be, p1_be;
   logic             ddr_busy, ddr_dout_ready;
   logic [DW-1:0]    ddr_dout;

   logic             p0_busy, p1_busy, p0_dout_ready, p1_dout_ready;
   logic [DW-1:0]    p0_dout, p1_dout;
   logic             ddr_clk, ddr_rd, ddr_we;
   logic [BCW-1:0]   ddr_bc;
   logic [AW-1:0]    ddr_addr;
   logic [DW-1:0]    ddr_din;
   logic [DW/8-1:0]  ddr_be;

   logic             fp_p0_busy, fp_p1_busy, fp_p0_rdy, fp_p1_rdy;
   logic [DW-1:0]    fp_p0_dout, fp_p1_dout;
   logic             fp_clk, fp_rd, fp_we;
   logic [BCW-1:0]   fp_bc;
   logic [AW-1:0]    fp_addr;
   logic [DW-1:0]    fp_din;
   logic [DW/8-1:0]  fp_be;

   int tests_run = 0;
   int tests_failed = 0;

   ddram_arb #(.AW(AW), .DW(DW), .BCW(BCW), .RR(1'b1)) dut (
      .clk(clk), .reset_n(reset_n),
      .p0_addr(p0_addr), .p0_burstcnt(p0_burstcnt), .p0_rd(p0_rd), .p0_we(p0_we),
      .p0_din(p0_din), .p0_be(p0_be), .p0_busy(p0_busy), .p0_dout(p0_dout),
      .p0_dout_ready(p0_dout_ready),
      .p1_addr(p1_addr), .p1_burstcnt(p1_burstcnt), .p1_rd(p1_rd), .p1_we(p1_we),
      .p1_din(p1_din), .p1_be(p1_be), .p1_busy(p1_busy), .p1_dout(p1_dout),
      .p1_dout_ready(p1_dout_ready),
      .DDRAM_CLK(ddr_clk), .DDRAM_BUSY(ddr_busy), .DDRAM_BURSTCNT(ddr_bc),
      .DDRAM_ADDR(ddr_addr), .DDRAM_DOUT(ddr_dout), .DDRAM_DOUT_READY(ddr_dout_ready),
      .DDRAM_RD(ddr_rd), .DDRAM_DIN(ddr_din), .DDRAM_BE(ddr_be), .DDRAM_WE(ddr_we)
   );

   ddram_arb #(.AW(AW), .DW(DW), .BCW(BCW), .RR(1'b0)) dut_fp (
      .clk(clk), .reset_n(reset_n),
      .p0_addr(p0_addr), .p0_burstcnt(p0_burstcnt), .p0_rd(p0_rd), .p0_we(p0_we),
      .p0_din(p0_din), .p0_be(p0_be), .p0_busy(fp_p0_busy), .p0_dout(fp_p0_dout),
      .p0_dout_ready(fp_p0_rdy),
      .p1_addr(p1_addr), .p1_burstcnt(p1_burstcnt), .p1_rd(p1_rd), .p1_we(p1_we),
      .p1_din(p1_din), .p1_be(p1_be), .p1_busy(fp_p1_busy), .p1_dout(fp_p1_dout),
      .p1_dout_ready(fp_p1_rdy),
      .DDRAM_CLK(fp_clk), .DDRAM_BUSY(ddr_busy), .DDRAM_BURSTCNT(fp_bc),
      .DDRAM_ADDR(fp_addr), .DDRAM_DOUT(ddr_dout), .DDRAM_DOUT_READY(ddr_dout_ready),
      .DDRAM_RD(fp_rd), .DDRAM_DIN(fp_din), .DDRAM_BE(fp_be), .DDRAM_WE(fp_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One record per clock cycle: inputs for the cycle and outputs expected in it.
   // sig = {DDRAM_RD, DDRAM_WE, p0_busy, p1_busy, p0_dout_ready, p1_dout_ready}
   typedef struct {
      logic       rst_n;
      logic       a_rd, a_we;
      logic [7:0] a_bc;
      logic       b_rd, b_we;
      logic [7:0] b_bc;
      logic       bsy, rdy;
      logic [5:0] sig;
      logic       own;
      logic [1:0] st;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic ar, input logic aw, input int abc,
                      input logic br, input logic bw, input int bbc,
                      input logic bsy, input logic rdy,
                      input logic [5:0] sig, input logic own, input logic [1:0] st);
      vec_t v;
      v.rst_n = rst; v.a_rd = ar; v.a_we = aw; v.a_bc = 8'(abc);
      v.b_rd = br; v.b_we = bw; v.b_bc = 8'(bbc);
      v.bsy = bsy; v.rdy = rdy; v.sig = sig; v.own = own; v.st = st;
      vecs.push_back(v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0]    act_sig;
      logic [1:0]    act_st;
      logic [AW-1:0] exp_addr;
      int            wr_beats;
      int            fp_beats;

      p0_addr = A0; p1_addr = A1;
      p0_din = 64'h0123_4567_89AB_CDEF; p1_din = 64'hFEDC_BA98_7654_3210;
      p0_be = 8'hFF; p1_be = 8'h0F;
      ddr_dout = 64'hA5A5_5A5A_DEAD_BEEF;

      // reset, with a stray DOUT_READY that must not leak
      add(0, 0,0,0, 0,0,0, 0,1, 6'b001100, 0, S_IDLE);
      add(0, 0,0,0, 0,0,0, 0,1, 6'b001100, 0, S_IDLE);
      // both ports write single beats, round robin: grants 0,1,0,1
      add(1, 0,1,1, 0,1,1, 0,0, 6'b001100, 0, S_IDLE);
      add(1, 0,1,1, 0,1,1, 0,0, 6'b010100, 0, S_CMD);
      add(1, 0,1,1, 0,1,1, 0,0, 6'b001100, 0, S_IDLE);
      add(1, 0,1,1, 0,1,1, 0,0, 6'b011000, 1, S_CMD);
      add(1, 0,1,1, 0,1,1, 0,0, 6'b001100, 1, S_IDLE);
      add(1, 0,1,1, 0,1,1, 0,0, 6'b010100, 0, S_CMD);
      add(1, 0,1,1, 0,1,1, 0,0, 6'b001100, 0, S_IDLE);
      add(1, 0,1,1, 0,1,1, 0,0, 6'b011000, 1, S_CMD);
      // port 0 read burst 4, beats return 3 cycles after the command
      add(1, 0,0,0, 0,0,0, 0,0, 6'b001100, 1, S_IDLE);
      add(1, 1,0,4, 0,0,0, 0,0, 6'b001100, 1, S_IDLE);
      add(1, 1,0,4, 0,0,0, 0,0, 6'b100100, 0, S_CMD);
      add(1, 0,0,4, 0,0,0, 0,0, 6'b001100, 0, S_RD);
      add(1, 0,0,4, 0,0,0, 0,0, 6'b001100, 0, S_RD);
      add(1, 0,0,4, 0,0,0, 0,1, 6'b001110, 0, S_RD);
      add(1, 0,0,4, 0,0,0, 0,1, 6'b001110, 0, S_RD);
      add(1, 0,0,4, 0,0,0, 0,1, 6'b001110, 0, S_RD);
      add(1, 0,0,4, 0,0,0, 0,1, 6'b001110, 0, S_RD);
      add(1, 0,0,0, 0,0,0, 0,1, 6'b001100, 0, S_IDLE);
      // port 1 write burst 3, DDRAM busy for 2 cycles on beats 1 and 2
      add(1, 0,0,0, 0,1,3, 0,0, 6'b001100, 0, S_IDLE);
      add(1, 0,0,0, 0,1,3, 1,0, 6'b011100, 1, S_CMD);
      add(1, 0,0,0, 0,1,3, 1,0, 6'b011100, 1, S_CMD);
      add(1, 0,0,0, 0,1,3, 0,0, 6'b011000, 1, S_CMD);
      add(1, 0,0,0, 0,1,3, 1,0, 6'b011100, 1, S_WR);
      add(1, 0,0,0, 0,1,3, 1,0, 6'b011100, 1, S_WR);
      add(1, 0,0,0, 0,1,3, 0,0, 6'b011000, 1, S_WR);
      add(1, 0,0,0, 0,1,3, 0,0, 6'b011000, 1, S_WR);
      // immediate follow-on request must still see an IDLE turnaround cycle
      add(1, 0,0,0, 0,1,1, 0,0, 6'b001100, 1, S_IDLE);
      add(1, 0,0,0, 0,1,1, 0,0, 6'b011000, 1, S_CMD);
      // burstcnt 0 read: done after one beat
      add(1, 1,0,0, 0,0,0, 0,0, 6'b001100, 1, S_IDLE);
      add(1, 1,0,0, 0,0,0, 0,0, 6'b100100, 0, S_CMD);
      add(1, 0,0,0, 0,0,0, 0,1, 6'b001110, 0, S_RD);
      add(1, 0,0,0, 0,0,0, 0,0, 6'b001100, 0, S_IDLE);
      // burstcnt 0 write: done after one accepted beat
      add(1, 0,0,0, 0,1,0, 0,0, 6'b001100, 0, S_IDLE);
      add(1, 0,0,0, 0,1,0, 0,0, 6'b011000, 1, S_CMD);
      add(1, 0,0,0, 0,0,0, 0,0, 6'b001100, 1, S_IDLE);
      // rd and we together: read issued, DDRAM_WE held low
      add(1, 1,1,1, 0,0,0, 0,0, 6'b001100, 1, S_IDLE);
      add(1, 1,1,1, 0,0,0, 0,0, 6'b100100, 0, S_CMD);
      add(1, 0,0,0, 0,0,0, 0,0, 6'b001100, 0, S_RD);
      add(1, 0,0,0, 0,0,0, 0,1, 6'b001110, 0, S_RD);
      add(1, 0,0,0, 0,0,0, 0,0, 6'b001100, 0, S_IDLE);
      // port 1 withdraws in CMD; last stays 0 so the next tie goes to port 1
      add(1, 0,0,0, 1,0,2, 0,0, 6'b001100, 0, S_IDLE);
      add(1, 0,0,0, 0,0,2, 0,0, 6'b001000, 1, S_CMD);
      add(1, 0,1,1, 0,1,1, 0,0, 6'b001100, 1, S_IDLE);
      add(1, 0,1,1, 0,1,1, 0,0, 6'b011000, 1, S_CMD);
      add(1, 0,0,0, 0,0,0, 0,0, 6'b001100, 1, S_IDLE);
      // reset during a read with 2 beats outstanding
      add(1, 1,0,4, 0,0,0, 0,0, 6'b001100, 1, S_IDLE);
      add(1, 1,0,4, 0,0,0, 0,0, 6'b100100, 0, S_CMD);
      add(1, 0,0,0, 0,0,0, 0,1, 6'b001110, 0, S_RD);
      add(1, 0,0,0, 0,0,0, 0,1, 6'b001110, 0, S_RD);
      add(0, 0,0,0, 0,0,0, 0,0, 6'b001100, 0, S_RD);
      add(1, 0,0,0, 0,0,0, 0,1, 6'b001100, 0, S_IDLE);
      add(1, 0,0,0, 0,0,0, 0,1, 6'b001100, 0, S_IDLE);

      wr_beats = 0;
      for (int i = 0; i < vecs.size(); i++) begin
         reset_n = vecs[i].rst_n;
         p0_rd = vecs[i].a_rd; p0_we = vecs[i].a_we; p0_burstcnt = vecs[i].a_bc;
         p1_rd = vecs[i].b_rd; p1_we = vecs[i].b_we; p1_burstcnt = vecs[i].b_bc;
         ddr_busy = vecs[i].bsy; ddr_dout_ready = vecs[i].rdy;
         @(negedge clk);
         act_sig  = {ddr_rd, ddr_we, p0_busy, p1_busy, p0_dout_ready, p1_dout_ready};
         act_st   = dut.state_reg;
         exp_addr = vecs[i].own ? A1 : A0;
         tests_run++;
         if (act_sig !== vecs[i].sig || ddr_addr !== exp_addr || act_st !== vecs[i].st) begin
            tests_failed++;
            $display("FAIL vec%0d: got rd,we,b0,b1,r0,r1=%b addr=%h state=%0d, expected %b addr=%h state=%0d",
                     i, act_sig, ddr_addr, act_st, vecs[i].sig, exp_addr, vecs[i].st);
         end else begin
            $display("[TB] vec%0d ok: sig=%b addr=%h state=%0d", i, act_sig, ddr_addr, act_st);
         end
         if (i >= 21 && i <= 27 && ddr_we && !ddr_busy) wr_beats++;
         @(posedge clk);
         #1;
      end

      tests_run++;
      if (wr_beats != 3) begin
         tests_failed++;
         $display("FAIL wr_beats: got %0d accepted write beats, expected 3", wr_beats);
      end else $display("[TB] wr_beats ok: 3");

      tests_run++;
      if (dut.last_reg !== 1'b1) begin
         tests_failed++;
         $display("FAIL last_after_reset: got %b, expected 1", dut.last_reg);
      end else $display("[TB] last_after_reset ok: 1");

      // Fixed priority: port 0 keeps winning while both request
      reset_n = 1'b0;
      p0_rd = 0; p1_rd = 0; p0_we = 0; p1_we = 0; ddr_busy = 0; ddr_dout_ready = 0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      p0_we = 1; p1_we = 1; p0_burstcnt = 8'd1; p1_burstcnt = 8'd1;
      fp_beats = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (fp_we) begin
            fp_beats++;
            tests_run++;
            if (fp_addr !== A0) begin
               tests_failed++;
               $display("FAIL fp_grant%0d: got addr=%h, expected %h", k, fp_addr, A0);
            end else $display("[TB] fp_grant%0d ok: addr=%h", k, fp_addr);
         end
         @(posedge clk); #1;
      end
      tests_run++;
      if (fp_beats != 4) begin
         tests_failed++;
         $display("FAIL fp_beats: got %0d writes, expected 4", fp_beats);
      end else $display("[TB] fp_beats ok: 4");

      p0_we = 0; p1_we = 0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ddram_arb.md
# ddram_arb

Two-port arbiter sharing the single DDRAM Avalon-MM burst interface of the `emu` top level between two requesters, such as a framebuffer reader and a loader or core memory port. It sequences one transaction at a time, either a read burst or a write burst, and locks the grant until the burst completes. It drives the `DDRAM_*` ports directly, replacing their tie-off.

## Interface
- `AW`, 29, address width (`DDRAM_ADDR`)
- `DW`, 64, data width
- `BCW`, 8, burst-count width
- `RR`, 1, 1 = round-robin; 0 = fixed priority, port 0 wins
- `clk`  in  1  system clock (`clk_sys`); `DDRAM_CLK = clk`
- `reset_n`  in  1  one clock; reset is synchronous and active-low
- `p0_addr`/`p1_addr`  in  AW  burst start address
- `p0_burstcnt`/`p1_burstcnt`  in  BCW  beats in burst; 0 is treated as 1
- `p0_rd`/`p1_rd`, `p0_we`/`p1_we`  in  1  read command / write beat, Avalon semantics, held while busy
- `p0_din`/`p1_din`  in  DW  write data; `p0_be`/`p1_be`  in  DW/8  byte enables
- `p0_busy`/`p1_busy`  out  1  waitrequest to the requester
- `p0_dout`/`p1_dout`  out  DW  read data, driven by `DDRAM_DOUT` to both ports
- `p0_dout_ready`/`p1_dout_ready`  out  1  read beat valid, owner port only
- `DDRAM_CLK`, `DDRAM_BURSTCNT`, `DDRAM_ADDR`, `DDRAM_RD`, `DDRAM_DIN`, `DDRAM_BE`, `DDRAM_WE`  out  master side
- `DDRAM_BUSY`, `DDRAM_DOUT`, `DDRAM_DOUT_READY`  in  master side

## Operation
- States: IDLE, CMD, RD_DATA, WR_DATA. Registers: `gnt` (owner index), `last` (last served), `cnt` (BCW bits).
- A port is pending when `rd|we` is high. If `rd` and `we` are both high, the command is treated as a read and `we` is masked.
- IDLE:
  - If no port is pending, stay in IDLE.
  - If exactly one port is pending, grant it.
  - If both are pending: with RR=1, grant `~last`; with RR=0, grant port 0.
  - Next state is CMD.
- CMD: the owner's addr, burstcnt, rd, we, din and be pass combinationally to DDRAM. The owner's busy follows `DDRAM_BUSY`.
  - Read accepted (`rd & ~DDRAM_BUSY`): `cnt <= max(burstcnt,1)`, go to RD_DATA.
  - Write accepted (`we & ~DDRAM_BUSY`):
    - Effective burst ≤ 1: go to IDLE and set `last <= gnt`.
    - Otherwise: `cnt <= burstcnt-1`, go to WR_DATA.
  - Owner drops both rd and we (protocol violation): go to IDLE. No command is issued and `last` is unchanged.
- RD_DATA: `DDRAM_RD=0` and `DDRAM_WE=0`; both busy outputs are 1.
  - Each `DDRAM_DOUT_READY` asserts the owner's `dout_ready` in the same cycle and decrements `cnt`.
  - The beat arriving at `cnt==1` sends the state to IDLE and sets `last <= gnt`.
- WR_DATA: the owner's we, din and be pass through. `DDRAM_RD` is forced to 0.
  - Each accepted beat decrements `cnt`.
  - The accepted beat at `cnt==1` sends the state to IDLE and sets `last <= gnt`.
- Non-owner busy is 1 in every state. Both busy outputs are 1 in IDLE.
- `DDRAM_DOUT_READY` outside RD_DATA is ignored and not forwarded.
- When not in CMD or WR_DATA, `DDRAM_ADDR`, `DDRAM_BURSTCNT`, `DDRAM_DIN` and `DDRAM_BE` show the owner's values. `DDRAM_RD` and `DDRAM_WE` are 0.
- `cnt` arithmetic is unsigned and modulo BCW bits. It never underflows because the exit condition is `cnt==1`.

## Timing
- Reset values: state IDLE, `gnt=0`, `last=1` (so the first tie goes to port 0), `cnt=0`. `DDRAM_RD=0` and `DDRAM_WE=0`. Both busy outputs are 1. Both dout_ready outputs are 0.
- Arbitration latency: a request first seen in IDLE on cycle N appears on DDRAM in cycle N+1.
- Turnaround: after the last read beat or last write beat, at least one IDLE cycle passes before the next command.
- Read data path is combinational: `pX_dout_ready` follows `DDRAM_DOUT_READY` with zero latency.
- Reset mid-burst: the state returns to IDLE. Read beats still arriving from DDR are dropped. Software must not reset during DDR traffic.
- There is only one outstanding transaction, so no read-data reordering is possible.

## Structure
- Package `ddram_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, CMD, RD_DATA, WR_DATA);
  - the `localparam` defaults for AW, DW and BCW.
- Sub-module `ddram_arb_pick`: combinational two-way picker with inputs `req[1:0]`, `last` and `RR`, and output `gnt_next`. It is reused by later multi-port arbiters.
- The top module holds the FSM, the counter and the port muxes.

## Test plan
- Port 0 reads addr 0x100 with burst 4, `DDRAM_BUSY=0`, 4 beats returned 3 cycles later:
  - `DDRAM_RD` is high for 1 cycle at N+1.
  - `p0_dout_ready` pulses 4 times; `p1_dout_ready` stays 0.
  - The state is back in IDLE after beat 4.
- Both ports continuously request single-beat writes with RR=1: grants alternate 0,1,0,1. With RR=0, only port 0 is served while it requests.
- Port 1 writes burst 3 while `DDRAM_BUSY` is high on beats 1 and 2 for 2 cycles each:
  - exactly 3 `DDRAM_WE & ~DDRAM_BUSY` beats;
  - `p0_busy` stays 1 throughout;
  - IDLE follows the third beat.
- `burstcnt=0`: a read completes after 1 returned beat, and a write completes after 1 accepted beat.
- `p0_rd` and `p0_we` both high: a read is issued and `DDRAM_WE` stays 0.
- `reset_n` low during RD_DATA with 2 beats outstanding:
  - next cycle the state is IDLE, both busy outputs are 1, and `last` is 1;
  - the later `DDRAM_DOUT_READY` pulses produce no `pX_dout_ready`.
